// File: rtl/mult4_dot_acc.sv
// mult4_dot_acc: dot-product accumulator that sits behind the 4x4 multiplier.
// Each accepted 8-bit product is added to a running group sum. A group closes
// on in_last or once MAX_LEN terms are in. The result (sum, term count,
// overflow flag) is presented on a registered valid/ready output.
//
// Optional build macro: MULT4_DOT_ACC_SATURATE_EN
//   defined   -> the sum clamps at 2^ACC_W-1 instead of wrapping
//   undefined -> the sum wraps mod 2^ACC_W
// In both builds out_ovf reports that the true sum passed 2^ACC_W-1.
//
// Handshake rules (both ports):
//   A transfer happens on a rising clk edge when valid & ready are both high.
//   Once out_valid is high, out_sum/out_len/out_ovf stay constant until the
//   transfer. in_ready = !out_valid | out_ready, so it never looks at in_valid.
//
// The FSM state is identical to out_valid: ACC (0) collecting, HOLD (1) result
// pending. It is observable directly through out_valid.
module mult4_dot_acc #(
  parameter  int ACC_W   = 12,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_len,
  output logic             out_ovf
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             close;
  logic             first_term;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] sum_next;
  logic             ovf_next;
  logic [LEN_W-1:0] cnt_inc;

  // Output decode: valid is the state itself, ready opens when the result
  // slot is empty or is being drained this cycle.
  always_comb begin
    out_valid = (state_q == ST_HOLD);
    in_ready  = (state_q == ST_ACC) || out_ready;
  end

  // Datapath arithmetic for the product being offered this cycle.
  always_comb begin
    accept     = in_valid && in_ready;
    first_term = (cnt_q == '0);
    cnt_inc    = cnt_q + LEN_W'(1);
    close      = accept && (in_last || (cnt_q == LEN_W'(MAX_LEN - 1)));
    if (first_term) begin
      sum_full = {{(ACC_W + 1 - 8){1'b0}}, in_p};
      ovf_next = 1'b0;
    end else begin
      sum_full = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, in_p};
      ovf_next = ovf_q || sum_full[ACC_W];
    end
`ifdef MULT4_DOT_ACC_SATURATE_EN
    sum_next = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    sum_next = sum_full[ACC_W-1:0];
`endif
  end

  // Next state: a closing accept always leaves a result pending; otherwise a
  // drained result returns to collecting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (close) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = close ? ST_HOLD : ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Next values for the group accumulator and the result registers.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_len_d = out_len_q;
    out_ovf_d = out_ovf_q;
    if (close) begin
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      out_sum_d = sum_next;
      out_len_d = cnt_inc;
      out_ovf_d = ovf_next;
    end else if (accept) begin
      acc_d = sum_next;
      cnt_d = cnt_inc;
      ovf_d = ovf_next;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // Accumulator and result registers; reset drops any partial group and any
  // pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_len_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_len_q <= out_len_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_sum = out_sum_q;
  assign out_len = out_len_q;
  assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_mult4_dot_acc.sv
// Bench for mult4_dot_acc: directed groups with hand-computed results pushed
// into expected queues; monitors pop and compare on each output transfer.
module tb_mult4_dot_acc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: default widths ----------------
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_p = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_sum;
  logic [4:0]  out_len;

  mult4_dot_acc #(.ACC_W(12), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_len(out_len), .out_ovf(out_ovf)
  );

  // ---------------- DUT B: ACC_W=10 for the overflow case ----------------
  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
  logic [7:0]  b_in_p = '0;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [9:0]  b_out_sum;
  logic [4:0]  b_out_len;

  mult4_dot_acc #(.ACC_W(10), .MAX_LEN(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_p(b_in_p), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_len(b_out_len), .out_ovf(b_out_ovf)
  );

  // ---------------- scoreboard ----------------
  // entry = {sum, len, ovf}
  logic [17:0] exp_q[$];
  logic [15:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor A: sample well after the negedge where stimulus settles.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got sum=%0d len=%0d, expected no result", out_sum, out_len);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("a_sum", int'(out_sum), int'(e[17:6]));
        check("a_len", int'(out_len), int'(e[5:1]));
        check("a_ovf", int'(out_ovf), int'(e[0]));
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    #2;
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got sum=%0d, expected no result", b_out_sum);
      end else begin
        logic [15:0] e;
        e = exp_b_q.pop_front();
        check("b_sum", int'(b_out_sum), int'(e[15:6]));
        check("b_len", int'(b_out_len), int'(e[5:1]));
        check("b_ovf", int'(b_out_ovf), int'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_a(input int sum, input int len, input int ovf);
    exp_q.push_back({12'(sum), 5'(len), 1'(ovf)});
  endtask

  // Offer one product; returns after the edge that accepted it.
  task automatic send(input logic [7:0] p, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_p = p; in_last = last;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk);
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_sum",   int'(out_sum),   0);
    check("reset_out_len",   int'(out_len),   0);
    check("reset_out_ovf",   int'(out_ovf),   0);
    check("reset_in_ready",  int'(in_ready),  1);

    // Basic three-term group.
    expect_a(90, 3, 0);
    send(8'd15, 1'b0);
    send(8'd30, 1'b0);
    send(8'd45, 1'b1);
    idle(2);

    // Forced close after 16 terms, then a fresh single-term group.
    expect_a(3600, 16, 0);
    expect_a(225, 1, 0);
    for (int i = 0; i < 16; i++) send(8'd225, 1'b0);
    send(8'd225, 1'b1);
    idle(2);

    // Stall: result pending while a product waits.
    out_ready = 1'b0;
    expect_a(5, 1, 0);
    expect_a(7, 1, 0);
    send(8'd5, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_p = 8'd7; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_in_ready",  int'(in_ready),  0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_sum",   int'(out_sum),   5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    idle(2);

    // Back-to-back single-term groups.
    for (int i = 1; i <= 4; i++) expect_a(i, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b1);
      if (i > 1) begin
        #1;
        check("b2b_out_valid", int'(out_valid), 1);
      end
    end
    idle(2);

    // Reset mid-group discards the partial sum.
    send(8'd9, 1'b0);
    send(8'd16, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_a(4, 1, 0);
    send(8'd4, 1'b1);
    idle(2);

    // Narrow accumulator: 5 x 225 = 1125 > 1023.
`ifdef MULT4_DOT_ACC_SATURATE_EN
    exp_b_q.push_back({10'd1023, 5'd5, 1'b1});
`else
    exp_b_q.push_back({10'd101, 5'd5, 1'b1});
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_p = 8'd225; b_in_last = (i == 4);
    end
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0;

    // Drain, bounded.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_b_q.size() != 0); i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    check("a_queue_left", exp_q.size(), 0);
    check("b_queue_left", exp_b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
